tpu_host_arbiter: RTL and testbench

//   Shares the TPU command port (matrix-memory write and compute start) between three hosts:

---
 rtl/tpu_host_pkg.sv | 41 ++++
 rtl/tpu_host_arbiter_if.sv | 36 +++
 rtl/tpu_host_arbiter_rr.sv | 35 +++
 rtl/tpu_host_arbiter.sv | 129 ++++++++++++
 tb/tb_tpu_host_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_host_pkg.sv
// Shared types and helpers for the three-host TPU command arbiter.
// Host numbering doubles as the round-robin scan order.
package tpu_host_pkg;

    localparam int NUM_HOSTS = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        START,
        WAIT_DONE
    } state_e;

    localparam logic [1:0] HOST_BTN  = 2'd0;
    localparam logic [1:0] HOST_UART = 2'd1;
    localparam logic [1:0] HOST_SPI  = 2'd2;

    typedef enum logic [1:0] {
        SEL_A   = 2'b00,
        SEL_B   = 2'b01,
        SEL_C   = 2'b10,
        SEL_BAD = 2'b11
    } sel_e;

    function automatic logic [1:0] next_host(input logic [1:0] id);
        return (id == HOST_SPI) ? HOST_BTN : id + 2'd1;
    endfunction

    function automatic logic [2:0] host_mask(input logic [1:0] id);
        return 3'b001 << id;
    endfunction

    function automatic logic [1:0] onehot_to_id(input logic [2:0] oh);
        case (oh)
            3'b010:  return HOST_UART;
            3'b100:  return HOST_SPI;
            default: return HOST_BTN;
        endcase
    endfunction

endpackage

// File: rtl/tpu_host_arbiter_if.sv
// Host request / matrix memory / TPU control bundle around the arbiter.
// The master side is the host front-ends plus the TPU core; the slave side is the arbiter.
interface tpu_host_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [2:0]          req_valid;
    logic [2:0]          req_start;
    logic [5:0]          req_sel;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*DATA_W-1:0] req_data;
    logic [2:0]          req_ready;
    logic [2:0]          req_done;
    logic [2:0]          req_err;
    logic                mem_we;
    logic [1:0]          mem_sel;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                tpu_start;
    logic                tpu_busy;
    logic                tpu_done;
    logic [1:0]          owner_id;

    modport master (
        output req_valid, req_start, req_sel, req_addr, req_data, tpu_busy, tpu_done,
        input  req_ready, req_done, req_err, mem_we, mem_sel, mem_addr, mem_wdata,
               tpu_start, owner_id
    );

    modport slave (
        input  req_valid, req_start, req_sel, req_addr, req_data, tpu_busy, tpu_done,
        output req_ready, req_done, req_err, mem_we, mem_sel, mem_addr, mem_wdata,
               tpu_start, owner_id
    );

endinterface

// File: rtl/tpu_host_arbiter_rr.sv
// Three-way round-robin arbiter: one-hot grant from the eligible mask, scanning
// upward from the pointer; the pointer moves past the winner on each advance strobe.
module rr_arbiter3
    import tpu_host_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] eligible,
    input  logic       advance,
    output logic [2:0] grant
);

    logic [1:0] ptr;
    logic [1:0] cand;

    always_comb begin
        grant = 3'b000;
        cand  = ptr;
        for (int k = 0; k < NUM_HOSTS; k++) begin
            if (grant == 3'b000 && eligible[cand]) begin
                grant[cand] = 1'b1;
            end
            cand = next_host(cand);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= HOST_BTN;
        end else if (advance) begin
            ptr <= next_host(onehot_to_id(grant));
        end
    end

endmodule

// File: rtl/tpu_host_arbiter.sv
// Shares the TPU command port (matrix write / compute start) between button, UART and SPI
// hosts with round-robin grants, one command per grant, and a done-timeout on computations.
module tpu_host_arbiter
    import tpu_host_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    tpu_host_arbiter_if.slave  bus
);

    // Expiry fires on the cycle the counter would step onto all-ones.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = ~TIMEOUT_W'(1);

    state_e               state;
    logic [2:0]           eligible;
    logic [2:0]           grant;
    logic                 advance;
    logic [1:0]           grant_id;
    logic                 grant_start;
    sel_e                 grant_sel;
    logic [ADDR_W-1:0]    grant_addr;
    logic [DATA_W-1:0]    grant_data;
    sel_e                 pl_sel;
    logic [ADDR_W-1:0]    pl_addr;
    logic [DATA_W-1:0]    pl_data;
    logic [TIMEOUT_W-1:0] tmo_cnt;

    // Starts wait out a busy TPU; writes stay eligible.
    always_comb begin
        eligible = bus.req_valid & ~(bus.req_start & {3{bus.tpu_busy}});
        advance  = (state == IDLE) && (grant != 3'b000);
    end

    rr_arbiter3 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .advance  (advance),
        .grant    (grant)
    );

    always_comb begin
        grant_id    = HOST_BTN;
        grant_start = 1'b0;
        grant_sel   = SEL_A;
        grant_addr  = '0;
        grant_data  = '0;
        for (int h = 0; h < NUM_HOSTS; h++) begin
            if (grant[h]) begin
                grant_id    = 2'(h);
                grant_start = bus.req_start[h];
                grant_sel   = sel_e'(bus.req_sel[2*h +: 2]);
                grant_addr  = bus.req_addr[h*ADDR_W +: ADDR_W];
                grant_data  = bus.req_data[h*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pl_sel        <= SEL_A;
            pl_addr       <= '0;
            pl_data       <= '0;
            tmo_cnt       <= '0;
            bus.req_ready <= 3'b000;
            bus.req_done  <= 3'b000;
            bus.req_err   <= 3'b000;
            bus.mem_we    <= 1'b0;
            bus.mem_sel   <= 2'b00;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.tpu_start <= 1'b0;
            bus.owner_id  <= HOST_BTN;
        end else begin
            bus.req_ready <= 3'b000;
            bus.req_done  <= 3'b000;
            bus.req_err   <= 3'b000;
            bus.mem_we    <= 1'b0;
            bus.tpu_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (advance) begin
                        bus.req_ready <= grant;
                        bus.owner_id  <= grant_id;
                        pl_sel        <= grant_sel;
                        pl_addr       <= grant_addr;
                        pl_data       <= grant_data;
                        state         <= grant_start ? START : WRITE;
                    end
                end
                WRITE: begin
                    if (pl_sel == SEL_BAD) begin
                        bus.req_err <= host_mask(bus.owner_id);
                    end else begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_sel   <= pl_sel;
                        bus.mem_addr  <= pl_addr;
                        bus.mem_wdata <= pl_data;
                    end
                    state <= IDLE;
                end
                START: begin
                    bus.tpu_start <= 1'b1;
                    tmo_cnt       <= '0;
                    state         <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A done arriving on the expiry cycle still counts as a completion.
                    if (bus.tpu_done) begin
                        bus.req_done <= host_mask(bus.owner_id);
                        state        <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus.req_err <= host_mask(bus.owner_id);
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_host_arbiter.sv
// Randomized self-checking bench for tpu_host_arbiter against a queue-based round-robin model.
module tb_tpu_host_arbiter;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int TIMEOUT_W = 12;
    localparam int TMO       = (1 << TIMEOUT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tpu_host_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    tpu_host_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;
    int ptr_m  = 0;

    logic [1:0]        w_sel  [3];
    logic [ADDR_W-1:0] w_addr [3];
    logic [DATA_W-1:0] w_data [3];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_host(input int h, input logic valid, input logic start,
                              input logic [1:0] sel, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] data);
        bus.req_valid[h]                  = valid;
        bus.req_start[h]                  = start;
        bus.req_sel[2*h +: 2]             = sel;
        bus.req_addr[h*ADDR_W +: ADDR_W]  = addr;
        bus.req_data[h*DATA_W +: DATA_W]  = data;
    endtask

    // Reference rule: first pending host scanning upward from the pointer, mod 3.
    function automatic int pick(input logic [2:0] pending);
        for (int k = 0; k < 3; k++) begin
            if (pending[(ptr_m + k) % 3]) return (ptr_m + k) % 3;
        end
        return -1;
    endfunction

    function automatic int onehot_id(input logic [2:0] oh);
        case (oh)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.req_ready !== 3'b000) break;
        end
    endtask

    // Issue simultaneous writes from the hosts in mask and follow every grant and its write cycle.
    task automatic run_writes(input logic [2:0] mask, input string tag);
        int         exp_q[$];
        logic [2:0] left;
        logic [2:0] exp_err;
        logic       exp_we;
        int         g, idx, last_g, last_cyc, cyc;
        left = mask;
        while (left != 3'b000) begin
            g = pick(left);
            exp_q.push_back(g);
            left[g] = 1'b0;
            ptr_m = (g + 1) % 3;
        end
        for (int h = 0; h < 3; h++) begin
            if (mask[h]) drive_host(h, 1'b1, 1'b0, w_sel[h], w_addr[h], w_data[h]);
        end
        idx = 0; last_g = -1; last_cyc = -10; cyc = 0;
        while (cyc < 40 && (idx < exp_q.size() || cyc <= last_cyc)) begin
            tick();
            cyc++;
            exp_we  = 1'b0;
            exp_err = 3'b000;
            if (last_g >= 0 && cyc == last_cyc + 1) begin
                if (w_sel[last_g] == 2'b11) exp_err = 3'b001 << last_g;
                else exp_we = 1'b1;
            end
            checks++;
            if ({bus.mem_we, bus.req_err} !== {exp_we, exp_err}) begin
                $display("[TB] FAIL %s strobes cyc %0d: got we=%b err=%b, expected we=%b err=%b",
                         tag, cyc, bus.mem_we, bus.req_err, exp_we, exp_err);
            end else passed++;
            if (exp_we) begin
                checks++;
                if ({bus.mem_sel, bus.mem_addr, bus.mem_wdata} !==
                    {w_sel[last_g], w_addr[last_g], w_data[last_g]}) begin
                    $display("[TB] FAIL %s payload: got sel=%b addr=%h data=%h, expected sel=%b addr=%h data=%h",
                             tag, bus.mem_sel, bus.mem_addr, bus.mem_wdata,
                             w_sel[last_g], w_addr[last_g], w_data[last_g]);
                end else passed++;
            end
            if (bus.req_ready !== 3'b000) begin
                g = onehot_id(bus.req_ready);
                checks++;
                if (idx >= exp_q.size() || bus.req_ready !== (3'b001 << exp_q[idx])) begin
                    $display("[TB] FAIL %s grant #%0d: got ready=%b, expected host %0d",
                             tag, idx, bus.req_ready, (idx < exp_q.size()) ? exp_q[idx] : -1);
                end else passed++;
                if (idx > 0) begin
                    checks++;
                    if (cyc - last_cyc != 2) begin
                        $display("[TB] FAIL %s grant spacing: got %0d cycles, expected 2",
                                 tag, cyc - last_cyc);
                    end else passed++;
                end
                if (g >= 0) begin
                    bus.req_valid[g] = 1'b0;
                    last_g = g;
                end
                last_cyc = cyc;
                idx++;
            end
        end
        checks++;
        if (idx != exp_q.size()) begin
            $display("[TB] FAIL %s grant count: got %0d, expected %0d", tag, idx, exp_q.size());
        end else passed++;
        bus.req_valid = 3'b000;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({bus.req_ready, bus.req_done, bus.req_err, bus.mem_we, bus.mem_sel, bus.mem_addr,
             bus.mem_wdata, bus.tpu_start, bus.owner_id} !== 39'd0) begin
            $display("[TB] FAIL reset outputs: got ready=%b done=%b err=%b we=%b addr=%h, expected all 0",
                     bus.req_ready, bus.req_done, bus.req_err, bus.mem_we, bus.mem_addr);
        end else passed++;
        rst_n = 1'b1;
        ptr_m = 0;
        tick();
    endtask

    task automatic test_all_writes();
        for (int h = 0; h < 3; h++) begin
            w_sel[h]  = 2'(h);
            w_addr[h] = ADDR_W'(8'h10 + h);
            w_data[h] = DATA_W'(16'h1000 * (h + 1));
        end
        run_writes(3'b111, "all_ptr0");
        run_writes(3'b010, "uart_only");
        run_writes(3'b111, "all_ptr2");
    endtask

    task automatic test_button_write();
        drive_host(0, 1'b1, 1'b0, 2'b00, 8'h00, 16'h3C00);
        tick();
        checks++;
        if (bus.req_ready !== 3'b001) begin
            $display("[TB] FAIL button ready: got %b, expected 001", bus.req_ready);
        end else passed++;
        bus.req_valid[0] = 1'b0;
        ptr_m = 1;
        tick();
        checks++;
        if ({bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== {1'b1, 2'b00, 8'h00, 16'h3C00}) begin
            $display("[TB] FAIL button write: got we=%b sel=%b addr=%h data=%h, expected 1 00 00 3c00",
                     bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata);
        end else passed++;
    endtask

    task automatic test_random_writes();
        logic [2:0] mask;
        for (int it = 0; it < 8; it++) begin
            mask = 3'($urandom_range(1, 7));
            for (int h = 0; h < 3; h++) begin
                w_sel[h]  = 2'($urandom_range(0, 3));
                w_addr[h] = ADDR_W'($urandom);
                w_data[h] = DATA_W'($urandom);
            end
            run_writes(mask, "random");
        end
    endtask

    task automatic test_start_done();
        logic stalled;
        drive_host(1, 1'b1, 1'b1, 2'b00, '0, '0);
        wait_ready();
        checks++;
        if ({bus.req_ready, bus.owner_id} !== {3'b010, 2'd1}) begin
            $display("[TB] FAIL uart start grant: got ready=%b owner=%0d, expected 010 owner 1",
                     bus.req_ready, bus.owner_id);
        end else passed++;
        bus.req_valid[1] = 1'b0;
        ptr_m = 2;
        drive_host(2, 1'b1, 1'b0, 2'b01, 8'h5A, 16'h4200);
        tick();
        checks++;
        if (bus.tpu_start !== 1'b1) begin
            $display("[TB] FAIL tpu_start latency: got %b, expected 1", bus.tpu_start);
        end else passed++;
        bus.tpu_busy = 1'b1;
        stalled = 1'b0;
        for (int i = 1; i < 20; i++) begin
            tick();
            if (bus.req_ready !== 3'b000 || bus.mem_we !== 1'b0 || bus.tpu_start !== 1'b0) stalled = 1'b1;
        end
        checks++;
        if (stalled) begin
            $display("[TB] FAIL wait_done stall: got activity while computing, expected none");
        end else passed++;
        bus.tpu_done = 1'b1;
        bus.tpu_busy = 1'b0;
        tick();
        bus.tpu_done = 1'b0;
        checks++;
        if ({bus.req_done, bus.req_err} !== {3'b010, 3'b000}) begin
            $display("[TB] FAIL uart done: got done=%b err=%b, expected 010 000", bus.req_done, bus.req_err);
        end else passed++;
        tick();
        checks++;
        if (bus.req_ready !== 3'b100) begin
            $display("[TB] FAIL spi after done: got ready=%b, expected 100", bus.req_ready);
        end else passed++;
        bus.req_valid[2] = 1'b0;
        ptr_m = 0;
        tick();
        checks++;
        if ({bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== {1'b1, 2'b01, 8'h5A, 16'h4200}) begin
            $display("[TB] FAIL spi write: got we=%b sel=%b addr=%h data=%h, expected 1 01 5a 4200",
                     bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata);
        end else passed++;
    endtask

    task automatic test_bad_sel();
        logic [25:0] prev;
        prev = {bus.mem_sel, bus.mem_addr, bus.mem_wdata};
        w_sel[2]  = 2'b11;
        w_addr[2] = 8'hC3;
        w_data[2] = 16'hBEEF;
        run_writes(3'b100, "bad_sel");
        checks++;
        if ({bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== prev) begin
            $display("[TB] FAIL bad_sel hold: got %h, expected %h",
                     {bus.mem_sel, bus.mem_addr, bus.mem_wdata}, prev);
        end else passed++;
    endtask

    task automatic test_busy_start();
        logic early;
        bus.tpu_busy = 1'b1;
        drive_host(2, 1'b1, 1'b1, 2'b00, '0, '0);
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.req_ready !== 3'b000) early = 1'b1;
        end
        checks++;
        if (early) begin
            $display("[TB] FAIL start while busy: got a grant, expected none");
        end else passed++;
        bus.tpu_busy = 1'b0;
        tick();
        checks++;
        if (bus.req_ready !== 3'b100) begin
            $display("[TB] FAIL start after busy: got ready=%b, expected 100", bus.req_ready);
        end else passed++;
        bus.req_valid[2] = 1'b0;
        ptr_m = 0;
        tick();
        bus.tpu_busy = 1'b1;
        tick();
        tick();
        bus.tpu_busy = 1'b0;
        bus.tpu_done = 1'b1;
        tick();
        bus.tpu_done = 1'b0;
        checks++;
        if (bus.req_done !== 3'b100) begin
            $display("[TB] FAIL spi start done: got %b, expected 100", bus.req_done);
        end else passed++;
    endtask

    task automatic test_timeout();
        int   k;
        logic early;
        drive_host(0, 1'b1, 1'b1, 2'b00, '0, '0);
        wait_ready();
        bus.req_valid[0] = 1'b0;
        ptr_m = 1;
        tick();
        bus.tpu_busy = 1'b1;
        k = -1;
        for (int i = 1; i <= TMO + 5; i++) begin
            tick();
            if (bus.req_err !== 3'b000 || bus.req_done !== 3'b000) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k != TMO || bus.req_err !== 3'b001 || bus.req_done !== 3'b000) begin
            $display("[TB] FAIL timeout: got event after %0d cycles err=%b done=%b, expected %0d err=001",
                     k, bus.req_err, bus.req_done, TMO);
        end else passed++;
        bus.tpu_busy = 1'b0;
        drive_host(0, 1'b1, 1'b0, 2'b01, 8'h11, 16'h1234);
        tick();
        checks++;
        if (bus.req_ready !== 3'b001) begin
            $display("[TB] FAIL idle after timeout: got ready=%b, expected 001", bus.req_ready);
        end else passed++;
        bus.req_valid[0] = 1'b0;
        tick();
        drive_host(0, 1'b1, 1'b1, 2'b00, '0, '0);
        wait_ready();
        bus.req_valid[0] = 1'b0;
        tick();
        bus.tpu_busy = 1'b1;
        early = 1'b0;
        for (int i = 1; i < TMO; i++) begin
            tick();
            if (bus.req_err !== 3'b000 || bus.req_done !== 3'b000) early = 1'b1;
        end
        bus.tpu_done = 1'b1;
        bus.tpu_busy = 1'b0;
        tick();
        bus.tpu_done = 1'b0;
        checks++;
        if (early || bus.req_done !== 3'b001 || bus.req_err !== 3'b000) begin
            $display("[TB] FAIL done on expiry: got early=%b done=%b err=%b, expected 0 001 000",
                     early, bus.req_done, bus.req_err);
        end else passed++;
    endtask

    task automatic test_reset_mid_wait();
        logic seen;
        drive_host(1, 1'b1, 1'b1, 2'b00, '0, '0);
        wait_ready();
        bus.req_valid[1] = 1'b0;
        tick();
        bus.tpu_busy = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.req_ready, bus.req_done, bus.req_err, bus.mem_we, bus.mem_sel, bus.mem_addr,
             bus.mem_wdata, bus.tpu_start, bus.owner_id} !== 39'd0) begin
            $display("[TB] FAIL mid-wait reset: got owner=%0d addr=%h data=%h, expected all 0",
                     bus.owner_id, bus.mem_addr, bus.mem_wdata);
        end else passed++;
        rst_n = 1'b1;
        bus.tpu_busy = 1'b0;
        ptr_m = 0;
        bus.tpu_done = 1'b1;
        tick();
        bus.tpu_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.req_done !== 3'b000 || bus.req_err !== 3'b000) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            $display("[TB] FAIL dropped start: got an acknowledge, expected none");
        end else passed++;
        for (int h = 0; h < 3; h++) begin
            w_sel[h]  = 2'($urandom_range(0, 2));
            w_addr[h] = ADDR_W'($urandom);
            w_data[h] = DATA_W'($urandom);
        end
        run_writes(3'b111, "after_reset");
    endtask

    initial begin
        bus.req_valid = 3'b000;
        bus.req_start = 3'b000;
        bus.req_sel   = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.tpu_busy  = 1'b0;
        bus.tpu_done  = 1'b0;
        test_reset();
        test_all_writes();
        test_button_write();
        test_random_writes();
        test_start_done();
        test_bad_sel();
        test_busy_start();
        test_timeout();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
